// File: rtl/mc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_pkg
// Description : Shared encodings for the multi-cycle main controller: FSM
//               states, opcode/funct values, ALU control codes and the
//               datapath mux select encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_ctrl_pkg;

    // FSM state encodings (exported on the debug state port)
    localparam logic [3:0] c_ST_INIT     = 4'd0;
    localparam logic [3:0] c_ST_FETCH    = 4'd1;
    localparam logic [3:0] c_ST_DECODE   = 4'd2;
    localparam logic [3:0] c_ST_EX_R     = 4'd3;
    localparam logic [3:0] c_ST_EX_I     = 4'd4;
    localparam logic [3:0] c_ST_MEM_ADDR = 4'd5;
    localparam logic [3:0] c_ST_MEM_RD   = 4'd6;
    localparam logic [3:0] c_ST_WB_MEM   = 4'd7;
    localparam logic [3:0] c_ST_MEM_WR   = 4'd8;
    localparam logic [3:0] c_ST_WB_R     = 4'd9;
    localparam logic [3:0] c_ST_WB_I     = 4'd10;
    localparam logic [3:0] c_ST_BRANCH   = 4'd11;
    localparam logic [3:0] c_ST_JUMP     = 4'd12;

    // Opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ADDIU = 6'b001001;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] c_FN_ADD  = 6'b100000;
    localparam logic [5:0] c_FN_ADDU = 6'b100001;
    localparam logic [5:0] c_FN_SUB  = 6'b100010;
    localparam logic [5:0] c_FN_AND  = 6'b100100;
    localparam logic [5:0] c_FN_OR   = 6'b100101;
    localparam logic [5:0] c_FN_NOR  = 6'b100111;

    // ALU control codes, shared with the ALU itself
    localparam logic [2:0] c_ALU_AND  = 3'b000;
    localparam logic [2:0] c_ALU_OR   = 3'b001;
    localparam logic [2:0] c_ALU_NOR  = 3'b011;
    localparam logic [2:0] c_ALU_ADD  = 3'b100;
    localparam logic [2:0] c_ALU_ADDU = 3'b101;
    localparam logic [2:0] c_ALU_SUB  = 3'b110;

    // ALU operand B select
    localparam logic [1:0] c_SRCB_REG    = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR   = 2'b01;
    localparam logic [1:0] c_SRCB_IMM    = 2'b10;
    localparam logic [1:0] c_SRCB_BRANCH = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Operations whose overflow flag is architecturally meaningful
    function automatic logic is_signed_op(input logic [5:0] opcode, input logic [5:0] funct);
        return (opcode == c_OP_ADDI) ||
               ((opcode == c_OP_RTYPE) && ((funct == c_FN_ADD) || (funct == c_FN_SUB)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_dec.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_dec
// Description : Combinational instruction decoder: maps (opcode, funct) to
//               the ALU control code, the immediate zero-extend select and a
//               legality flag covering every supported instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_imm_zext,
    output logic       o_legal
);

    // Decode opcode/funct; non-ALU instructions default to ADDU
    always_comb begin
        o_alu_ctrl = c_ALU_ADDU;
        o_imm_zext = 1'b0;
        o_legal    = 1'b1;
        case (i_opcode)
            c_OP_RTYPE: begin
                case (i_funct)
                    c_FN_ADD:  o_alu_ctrl = c_ALU_ADD;
                    c_FN_ADDU: o_alu_ctrl = c_ALU_ADDU;
                    c_FN_SUB:  o_alu_ctrl = c_ALU_SUB;
                    c_FN_AND:  o_alu_ctrl = c_ALU_AND;
                    c_FN_OR:   o_alu_ctrl = c_ALU_OR;
                    c_FN_NOR:  o_alu_ctrl = c_ALU_NOR;
                    default:   o_legal    = 1'b0;
                endcase
            end
            c_OP_ADDI:  o_alu_ctrl = c_ALU_ADD;
            c_OP_ADDIU: o_alu_ctrl = c_ALU_ADDU;
            c_OP_ANDI: begin
                o_alu_ctrl = c_ALU_AND;
                o_imm_zext = 1'b1;
            end
            c_OP_ORI: begin
                o_alu_ctrl = c_ALU_OR;
                o_imm_zext = 1'b1;
            end
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_J: o_alu_ctrl = c_ALU_ADDU;
            default: o_legal = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mc_main_ctrl
// Description : Multi-cycle main control FSM feeding the ALU and datapath.
//               Moore outputs decoded from state; pc_wr in BRANCH follows
//               the ALU zero flag. Build option MC_OVF_SUPPRESS_EN blocks
//               register write-back of signed results that overflowed.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit RESET_PC_WR = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       ovf,
    output logic [2:0] alu_ctrl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic       pc_wr,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [2:0] w_dec_alu_ctrl;
    logic       w_dec_imm_zext;
    logic       w_dec_legal;
    logic       w_wb_reg_wr;

    mc_alu_dec u_alu_dec (
        .i_opcode   (opcode),
        .i_funct    (funct),
        .o_alu_ctrl (w_dec_alu_ctrl),
        .o_imm_zext (w_dec_imm_zext),
        .o_legal    (w_dec_legal)
    );

`ifdef MC_OVF_SUPPRESS_EN
    logic r_ovf_q;

    // Hold the EX-stage overflow of signed ops into WB, where ALU inputs change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_q <= 1'b0;
        end else if ((r_state == c_ST_EX_R) || (r_state == c_ST_EX_I)) begin
            r_ovf_q <= ovf & is_signed_op(opcode, funct);
        end else begin
            r_ovf_q <= 1'b0;
        end
    end

    assign w_wb_reg_wr = ~r_ovf_q;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = ovf;
    assign w_wb_reg_wr  = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state sequencing; illegal instructions fall straight back to FETCH
    always_comb begin
        w_next_state = c_ST_INIT;
        case (r_state)
            c_ST_INIT:   w_next_state = c_ST_FETCH;
            c_ST_FETCH:  w_next_state = c_ST_DECODE;
            c_ST_DECODE: begin
                w_next_state = c_ST_FETCH;
                if (w_dec_legal) begin
                    case (opcode)
                        c_OP_RTYPE:                  w_next_state = c_ST_EX_R;
                        c_OP_LW, c_OP_SW:            w_next_state = c_ST_MEM_ADDR;
                        c_OP_BEQ:                    w_next_state = c_ST_BRANCH;
                        c_OP_J:                      w_next_state = c_ST_JUMP;
                        c_OP_ADDI, c_OP_ADDIU,
                        c_OP_ANDI, c_OP_ORI:         w_next_state = c_ST_EX_I;
                        default:                     w_next_state = c_ST_FETCH;
                    endcase
                end
            end
            c_ST_EX_R:     w_next_state = c_ST_WB_R;
            c_ST_EX_I:     w_next_state = c_ST_WB_I;
            c_ST_MEM_ADDR: w_next_state = (opcode == c_OP_LW) ? c_ST_MEM_RD : c_ST_MEM_WR;
            c_ST_MEM_RD:   w_next_state = c_ST_WB_MEM;
            c_ST_WB_MEM,
            c_ST_MEM_WR,
            c_ST_WB_R,
            c_ST_WB_I,
            c_ST_BRANCH,
            c_ST_JUMP:     w_next_state = c_ST_FETCH;
            default:       w_next_state = c_ST_INIT;
        endcase
    end

    // Output decode from state; everything not named in a state stays low
    always_comb begin
        alu_ctrl   = 3'b000;
        alu_src_a  = 1'b0;
        alu_src_b  = c_SRCB_REG;
        imm_zext   = 1'b0;
        pc_wr      = 1'b0;
        pc_src     = c_PCSRC_ALU;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            c_ST_INIT: pc_wr = RESET_PC_WR;
            c_ST_FETCH: begin
                mem_rd    = 1'b1;
                ir_wr     = 1'b1;
                alu_src_b = c_SRCB_FOUR;
                alu_ctrl  = c_ALU_ADDU;
                pc_wr     = 1'b1;
            end
            c_ST_DECODE: begin
                alu_src_b  = c_SRCB_BRANCH;
                alu_ctrl   = c_ALU_ADDU;
                illegal_op = ~w_dec_legal;
            end
            c_ST_EX_R: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_REG;
                alu_ctrl  = w_dec_alu_ctrl;
            end
            c_ST_EX_I: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                alu_ctrl  = w_dec_alu_ctrl;
                imm_zext  = w_dec_imm_zext;
            end
            c_ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                alu_ctrl  = c_ALU_ADDU;
            end
            c_ST_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
            end
            c_ST_WB_MEM: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
            end
            c_ST_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
            end
            c_ST_WB_R: begin
                reg_wr  = w_wb_reg_wr;
                reg_dst = 1'b1;
            end
            c_ST_WB_I: reg_wr = w_wb_reg_wr;
            c_ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_REG;
                alu_ctrl  = c_ALU_SUB;
                pc_src    = c_PCSRC_ALUOUT;
                pc_wr     = zero;
            end
            c_ST_JUMP: begin
                pc_src = c_PCSRC_JUMP;
                pc_wr  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_main_ctrl
// Description : Self-checking bench for mc_main_ctrl. Each instruction is
//               classified from its mnemonic rules and expanded into the
//               expected per-cycle control words, compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_main_ctrl;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_e;

    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       src_a;
        logic [1:0] src_b;
        logic       zext;
        logic       pc_wr;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } ctl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero, ovf;
    logic [2:0] alu_ctrl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext, pc_wr;
    logic [1:0] pc_src;
    logic       iord, mem_rd, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state;
    ctl_t       act;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero(zero), .ovf(ovf), .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_zext(imm_zext), .pc_wr(pc_wr),
        .pc_src(pc_src), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .ir_wr(ir_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .state(state)
    );

    assign act = {alu_ctrl, alu_src_a, alu_src_b, imm_zext, pc_wr, pc_src, iord,
                  mem_rd, mem_wr, ir_wr, reg_wr, reg_dst, mem_to_reg, illegal_op};

    // Instruction-set reference: kind, ALU op, zero-extend, signed-overflow relevance
    function automatic void classify(input logic [5:0] op, input logic [5:0] fn,
                                     output kind_e k, output logic [2:0] alu,
                                     output logic zx, output bit sgn);
        k = K_ILL; alu = 3'b101; zx = 1'b0; sgn = 1'b0;
        case (op)
            6'b000000: begin
                k = K_R;
                case (fn)
                    6'b100000: begin alu = 3'b100; sgn = 1'b1; end
                    6'b100001: alu = 3'b101;
                    6'b100010: begin alu = 3'b110; sgn = 1'b1; end
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b100111: alu = 3'b011;
                    default:   k = K_ILL;
                endcase
            end
            6'b001000: begin k = K_I; alu = 3'b100; sgn = 1'b1; end
            6'b001001: begin k = K_I; alu = 3'b101; end
            6'b001100: begin k = K_I; alu = 3'b000; zx = 1'b1; end
            6'b001101: begin k = K_I; alu = 3'b001; zx = 1'b1; end
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b000010: k = K_J;
            default:   k = K_ILL;
        endcase
    endfunction

    function automatic int instr_len(input kind_e k);
        case (k)
            K_LW:         return 5;
            K_R, K_I, K_SW: return 4;
            K_BEQ, K_J:   return 3;
            default:      return 2;
        endcase
    endfunction

    // Expected control word for cycle 'step' of an instruction (0 = fetch)
    function automatic ctl_t exp_ctl(input kind_e k, input int step, input logic [2:0] alu,
                                     input logic zx, input bit sgn, input logic z,
                                     input logic ovf_ex);
        ctl_t c;
        logic wb_ok;
        c = '0;
`ifdef MC_OVF_SUPPRESS_EN
        wb_ok = !(sgn && ovf_ex);
`else
        wb_ok = 1'b1;
`endif
        if (step == 0) begin
            c.mem_rd = 1'b1; c.ir_wr = 1'b1; c.src_b = 2'b01; c.alu_ctrl = 3'b101; c.pc_wr = 1'b1;
        end else if (step == 1) begin
            c.src_b = 2'b11; c.alu_ctrl = 3'b101; c.illegal = (k == K_ILL);
        end else if (step == 2) begin
            case (k)
                K_R:   begin c.src_a = 1'b1; c.alu_ctrl = alu; end
                K_I:   begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu_ctrl = alu; c.zext = zx; end
                K_LW, K_SW: begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu_ctrl = 3'b101; end
                K_BEQ: begin c.src_a = 1'b1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01; c.pc_wr = z; end
                K_J:   begin c.pc_src = 2'b10; c.pc_wr = 1'b1; end
                default: ;
            endcase
        end else if (step == 3) begin
            case (k)
                K_R:  begin c.reg_wr = wb_ok; c.reg_dst = 1'b1; end
                K_I:  c.reg_wr = wb_ok;
                K_LW: begin c.mem_rd = 1'b1; c.iord = 1'b1; end
                K_SW: begin c.mem_wr = 1'b1; c.iord = 1'b1; end
                default: ;
            endcase
        end else if (step == 4) begin
            c.reg_wr = 1'b1; c.mem_to_reg = 1'b1;
        end
        return c;
    endfunction

    // Run one instruction starting in FETCH (just after a rising edge).
    // ovf_ex_i / zero_i < 0 means randomise; stop_at >= 0 halts after that cycle's check.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int ovf_ex_i,
                             input int zero_i, input int stop_at, input string name);
        kind_e      k;
        logic [2:0] alu;
        logic       zx;
        bit         sgn;
        logic       ovf_ex;
        ctl_t       e;
        int         len;
        classify(op, fn, k, alu, zx, sgn);
        len    = instr_len(k);
        ovf_ex = 1'b0;
        opcode = op;
        funct  = fn;
        for (int s = 0; s < len; s++) begin
            if (ovf_ex_i < 0)   ovf = 1'($urandom_range(1));
            else if (s == 2)    ovf = ovf_ex_i[0];
            else                ovf = 1'b0;
            zero = (zero_i < 0) ? 1'($urandom_range(1)) : zero_i[0];
            if (s == 2) ovf_ex = ovf;
            @(negedge clk);
            e = exp_ctl(k, s, alu, zx, sgn, zero, ovf_ex);
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s op=%b fn=%b cycle %0d: got %h expected %h",
                         name, op, fn, s, act, e);
            end
            if (s == stop_at) return;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_zero(input string name);
        n_checks++;
        if (act !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected 0", name, act);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; ovf = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("init_cycle");
        @(posedge clk); #1;
        // lw abandoned in MEM_RD by an asynchronous reset
        run_instr(6'b100011, 6'h00, 0, 0, 3, "lw_before_reset");
        #1 rst_n = 1'b0;
        #1 check_zero("reset_async");
        @(posedge clk); #1;
        check_zero("reset_held_edge");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("init_after_reset");
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b100000, 0, 0, -1, "add");
        run_instr(6'b000000, 6'b100001, 0, 0, -1, "addu");
        run_instr(6'b000000, 6'b100100, 0, 0, -1, "and");
        run_instr(6'b000000, 6'b100101, 0, 0, -1, "or");
        run_instr(6'b000000, 6'b100111, 0, 0, -1, "nor");
    endtask

    task automatic test_mem();
        run_instr(6'b100011, 6'h15, 0, 0, -1, "lw");
        run_instr(6'b101011, 6'h2a, 0, 0, -1, "sw");
    endtask

    task automatic test_branch_jump();
        run_instr(6'b000100, 6'h00, 0, 1, -1, "beq_taken");
        run_instr(6'b000100, 6'h00, 0, 0, -1, "beq_not_taken");
        run_instr(6'b000010, 6'h00, 0, 0, -1, "j");
    endtask

    task automatic test_overflow();
        run_instr(6'b000000, 6'b100010, 1, 0, -1, "sub_ovf");
        run_instr(6'b000000, 6'b100001, 1, 0, -1, "addu_ovf");
        run_instr(6'b000000, 6'b100000, 1, 0, -1, "add_ovf");
        run_instr(6'b001000, 6'h00, 1, 0, -1, "addi_ovf");
        run_instr(6'b001001, 6'h00, 1, 0, -1, "addiu_ovf");
        run_instr(6'b000000, 6'b100010, 0, 0, -1, "sub_no_ovf");
    endtask

    task automatic test_immediate();
        run_instr(6'b001101, 6'h3f, 0, 0, -1, "ori");
        run_instr(6'b001100, 6'h00, 0, 0, -1, "andi");
        run_instr(6'b001000, 6'h00, 0, 0, -1, "addi");
        run_instr(6'b001001, 6'h00, 0, 0, -1, "addiu");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'h00, 0, 0, -1, "illegal_op");
        run_instr(6'b000000, 6'b000000, 0, 0, -1, "illegal_funct");
        run_instr(6'b000000, 6'b100011, 0, 0, -1, "illegal_funct2");
    endtask

    task automatic test_random();
        logic [5:0] ops [9];
        logic [5:0] fns [6];
        logic [5:0] op, fn;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                6'b001000, 6'b001001, 6'b001100, 6'b001101};
        fns = '{6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101, 6'b100111};
        for (int i = 0; i < 80; i++) begin
            op = ($urandom_range(9) < 8) ? ops[$urandom_range(8)] : 6'($urandom);
            fn = ($urandom_range(9) < 8) ? fns[$urandom_range(5)] : 6'($urandom);
            run_instr(op, fn, -1, -1, -1, "random");
        end
    endtask

    task automatic test_back_to_back_end();
        ctl_t e;
        @(negedge clk);
        e = exp_ctl(K_ILL, 0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL final_fetch: got %h expected %h", act, e);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_mem();
        test_branch_jump();
        test_overflow();
        test_immediate();
        test_illegal();
        test_random();
        test_back_to_back_end();
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
